// File: rtl/squeeze_fsm_if.sv
// Squeeze-controller signal bundle: request/permutation handshake plus the
// output-buffer handshake shared with dump_fsm.
interface squeeze_fsm_if #(
    parameter int LEN_W = 32
);
    logic             start_in;
    logic [LEN_W-1:0] output_len_in;
    logic             perm_done_in;
    logic             perm_start_out;
    logic             output_buffer_available_wr;
    logic             last_output_block_clr;
    logic             output_buffer_we;
    logic             last_output_block;
    logic [7:0]       last_block_bytes;
    logic             busy_out;
    logic             done_out;

    modport master (
        input  start_in, output_len_in, perm_done_in,
        input  output_buffer_available_wr, last_output_block_clr,
        output perm_start_out, output_buffer_we, last_output_block,
        output last_block_bytes, busy_out, done_out
    );

    modport slave (
        output start_in, output_len_in, perm_done_in,
        output output_buffer_available_wr, last_output_block_clr,
        input  perm_start_out, output_buffer_we, last_output_block,
        input  last_block_bytes, busy_out, done_out
    );
endinterface

// File: rtl/squeeze_fsm.sv
// Squeeze-phase controller: hands one rate block at a time to the output
// buffer and requests further permutations until the requested length is covered.
module squeeze_fsm #(
    parameter int RATE_BYTES = 168,
    parameter int LEN_W      = 32
) (
    input logic          clk,
    input logic          rst_n,
    squeeze_fsm_if.master sq
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_PERM,
        S_WAIT_BUF,
        S_DRAIN
    } state_t;

    localparam logic [LEN_W-1:0] RATE_L = LEN_W'(RATE_BYTES);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             last_q, last_d;
    logic [7:0]       lbb_q, lbb_d;

    logic is_last;
    logic we;
    logic perm_start;
    logic done;

    // Comparing before subtracting keeps remaining from ever wrapping.
    assign is_last = (remaining_q <= RATE_L);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        last_d      = last_q;
        lbb_d       = lbb_q;
        we          = 1'b0;
        perm_start  = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sq.start_in) begin
                    if (sq.output_len_in == '0) begin
                        done = 1'b1;
                    end else begin
                        remaining_d = sq.output_len_in;
                        state_d     = S_WAIT_PERM;
                    end
                end
            end
            S_WAIT_PERM: begin
                if (sq.perm_done_in) begin
                    state_d = S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: begin
                if (sq.output_buffer_available_wr) begin
                    we = 1'b1;
                    if (is_last) begin
                        last_d      = 1'b1;
                        lbb_d       = remaining_q[7:0];
                        remaining_d = '0;
                        state_d     = S_DRAIN;
                    end else begin
                        remaining_d = remaining_q - RATE_L;
                        perm_start  = 1'b1;
                        state_d     = S_WAIT_PERM;
                    end
                end
            end
            S_DRAIN: begin
                if (sq.last_output_block_clr) begin
                    last_d  = 1'b0;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            last_q      <= 1'b0;
            lbb_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            last_q      <= last_d;
            lbb_q       <= lbb_d;
        end
    end

    assign sq.output_buffer_we  = we;
    assign sq.perm_start_out    = perm_start;
    // A start pulse held during reset must not leak through as a zero-length done.
    assign sq.done_out          = done & rst_n;
    assign sq.last_output_block = last_q | (we & is_last);
    assign sq.last_block_bytes  = lbb_q;
    assign sq.busy_out          = (state_q != S_IDLE);
endmodule
